// File: rtl/core_reg_writeback_pkg.sv
// Shared micro-architecture types for the writeback path: register-file
// request struct, datapath widths and the program-counter register number.
package core_reg_writeback_pkg;

  typedef logic [31:0] word;
  typedef logic [3:0]  reg_num;
  typedef logic [4:0]  psr_mode;
  typedef logic [29:0] ptr;

  typedef struct packed {
    reg_num  r;
    psr_mode mode;
    word     value;
  } wb_req;

  localparam reg_num REG_PC = 4'd15;

endpackage

// File: rtl/core_reg_wb_fifo.sv
// Load-result FIFO: each entry carries a live bit so that a younger ALU write
// can retire an older queued load without disturbing queue order.
module core_reg_wb_fifo
  import core_reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        push_live,
  input  wb_req       push_req,
  input  logic        pop,
  input  logic        kill,
  input  reg_num      kill_r,
  output logic        full,
  output logic        empty,
  output wb_req       head,
  output logic        head_live,
  output logic [15:0] pending
);

  localparam int AW = $clog2(DEPTH);

  wb_req             mem [DEPTH];
  logic [DEPTH-1:0]  live, live_nxt;
  logic [AW:0]       wptr, rptr;
  logic [AW-1:0]     widx, ridx;

  assign widx      = wptr[AW-1:0];
  assign ridx      = rptr[AW-1:0];
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (widx == ridx);
  assign head      = mem[ridx];
  assign head_live = live[ridx];

  // Slots outside the occupied window always hold live=0, so the mask
  // and kill logic can scan every slot without consulting the pointers.
  always_comb begin
    live_nxt = live;
    for (int i = 0; i < DEPTH; i++)
      if (kill && live[i] && (mem[i].r == kill_r)) live_nxt[i] = 1'b0;
    if (pop)  live_nxt[ridx] = 1'b0;
    if (push) live_nxt[widx] = push_live;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i]) pending[mem[i].r] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      live <= '0;
    end else begin
      live <= live_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (push) mem[widx] <= push_req;

endmodule

// File: rtl/core_reg_writeback.sv
// Writeback arbiter for the single register-file write port: ALU first,
// then queued loads, then a bypassed load; r15 writes become branches.
module core_reg_writeback
  import core_reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  reg_num      alu_r,
  input  psr_mode     alu_mode,
  input  word         alu_value,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  reg_num      ld_r,
  input  psr_mode     ld_mode,
  input  word         ld_value,
  output reg_num      wr_r,
  output psr_mode     wr_mode,
  output logic        wr_enable,
  output word         wr_value,
  output logic        branch,
  output ptr          branch_target,
  output logic [15:0] pending
);

  wb_req alu_req, ld_req, head, sel;
  logic  full, empty, head_live;
  logic  ld_acc, push, push_live, pop, sel_vld;

  assign alu_req  = '{r: alu_r, mode: alu_mode, value: alu_value};
  assign ld_req   = '{r: ld_r,  mode: ld_mode,  value: ld_value};
  assign ld_ready = !full;
  assign ld_acc   = ld_valid && !full;

  // A load arriving alongside an ALU write to the same register is the
  // older of the two, so it is queued already dead.
  always_comb begin
    sel_vld   = 1'b0;
    sel       = '0;
    push      = 1'b0;
    push_live = 1'b1;
    pop       = 1'b0;
    if (alu_valid) begin
      sel_vld   = 1'b1;
      sel       = alu_req;
      push      = ld_acc;
      push_live = (ld_r != alu_r);
    end else if (!empty) begin
      pop     = 1'b1;
      sel     = head;
      sel_vld = head_live;
      push    = ld_acc;
    end else if (ld_acc) begin
      sel_vld = 1'b1;
      sel     = ld_req;
    end
  end

  core_reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_live (push_live),
    .push_req  (ld_req),
    .pop       (pop),
    .kill      (alu_valid),
    .kill_r    (alu_r),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .head_live (head_live),
    .pending   (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_enable     <= 1'b0;
      branch        <= 1'b0;
      wr_r          <= '0;
      wr_mode       <= '0;
      wr_value      <= '0;
      branch_target <= '0;
    end else begin
      wr_enable <= sel_vld && (sel.r != REG_PC);
      branch    <= sel_vld && (sel.r == REG_PC);
      if (sel_vld) begin
        wr_r     <= sel.r;
        wr_mode  <= sel.mode;
        wr_value <= sel.value;
        if (sel.r == REG_PC) branch_target <= sel.value[31:2];
      end
    end
  end

endmodule

// File: tb/tb_core_reg_writeback.sv
// Directed bench for core_reg_writeback: expected writes/branches go into a
// scoreboard with their due cycle and are checked as the port fires.
module tb_core_reg_writeback;
  import core_reg_writeback_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, ld_ready;
  reg_num      alu_r = '0, ld_r = '0, wr_r;
  psr_mode     alu_mode = '0, ld_mode = '0, wr_mode;
  word         alu_value = '0, ld_value = '0, wr_value;
  logic        wr_enable, branch;
  ptr          branch_target;
  logic [15:0] pending;

  core_reg_writeback #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_r(alu_r), .alu_mode(alu_mode), .alu_value(alu_value),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_r(ld_r), .ld_mode(ld_mode), .ld_value(ld_value),
    .wr_r(wr_r), .wr_mode(wr_mode), .wr_enable(wr_enable), .wr_value(wr_value),
    .branch(branch), .branch_target(branch_target), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit      br;
    reg_num  r;
    psr_mode mode;
    word     v;
    int      at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // {branch, wr_enable, r, mode, payload, cycle}
  logic [73:0] obs, expv;

  always @(negedge clk) begin
    if (rst_n && (wr_enable || branch)) begin
      total++;
      if (sb.size() == 0) begin
        assert (0) else begin
          bad++;
          $error("FAIL unexpected_write obs br=%0b en=%0b r=%0d val=%h cyc=%0d required=none",
                 branch, wr_enable, wr_r, wr_value, cyc);
        end
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.br) begin
          obs  = {branch, wr_enable, 4'h0, 5'h0, 2'b00, branch_target, cyc};
          expv = {1'b1, 1'b0, 4'h0, 5'h0, 2'b00, e.v[31:2], e.at};
        end else begin
          obs  = {branch, wr_enable, wr_r, wr_mode, wr_value, cyc};
          expv = {1'b0, 1'b1, e.r, e.mode, e.v, e.at};
        end
        assert (obs === expv) else begin
          bad++;
          $error("FAIL writeback obs=%h required=%h", obs, expv);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s obs=%h required=%h", tag, o, x);
    end
  endtask

  task automatic expect_wb(input reg_num r, input psr_mode m, input word v, input int at);
    exp_t e;
    e.br = (r == 4'd15); e.r = r; e.mode = m; e.v = v; e.at = at;
    sb.push_back(e);
  endtask

  task automatic alu(input reg_num r, input psr_mode m, input word v);
    alu_valid = 1'b1; alu_r = r; alu_mode = m; alu_value = v;
  endtask

  task automatic ld(input reg_num r, input psr_mode m, input word v);
    ld_valid = 1'b1; ld_r = r; ld_mode = m; ld_value = v;
  endtask

  task automatic idle();
    alu_valid = 1'b0; ld_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    check("reset_state",
          {wr_enable, branch, ld_ready, wr_r, wr_mode, wr_value, branch_target, pending},
          {3'b001, 4'h0, 5'h0, 32'h0, 30'h0, 16'h0});
    rst_n = 1'b1;
    tick();

    // single ALU write
    alu(4'd3, 5'h10, 32'h1234_5678); expect_wb(4'd3, 5'h10, 32'h1234_5678, cyc + 1);
    tick(); idle(); tick(); tick();

    // bypassed load, never queued
    check("ld_ready_idle", ld_ready, 1'b1);
    ld(4'd5, 5'h13, 32'hAAAA_0000); expect_wb(4'd5, 5'h13, 32'hAAAA_0000, cyc + 1);
    tick(); check("pending_bypass", pending, 16'h0);
    idle(); tick();

    // ALU busy 4 cycles; two loads queue, third is refused
    alu(4'd8, 5'h10, 32'h8); ld(4'd1, 5'h11, 32'h1111); expect_wb(4'd8, 5'h10, 32'h8, cyc + 1);
    tick();
    alu(4'd9, 5'h10, 32'h9); ld(4'd2, 5'h12, 32'h2222); expect_wb(4'd9, 5'h10, 32'h9, cyc + 1);
    tick();
    check("pending_two", pending, 16'h0006);
    check("ld_ready_full", ld_ready, 1'b0);
    alu(4'd10, 5'h10, 32'hA); ld(4'd3, 5'h13, 32'h3333); expect_wb(4'd10, 5'h10, 32'hA, cyc + 1);
    tick();
    alu(4'd11, 5'h10, 32'hB); expect_wb(4'd11, 5'h10, 32'hB, cyc + 1);
    tick();
    check("ld_ready_still_full", ld_ready, 1'b0);
    idle();
    expect_wb(4'd1, 5'h11, 32'h1111, cyc + 1);
    expect_wb(4'd2, 5'h12, 32'h2222, cyc + 2);
    tick(); tick(); tick();
    check("pending_drained", {ld_ready, pending}, {1'b1, 16'h0});

    // queued load killed by a younger ALU write
    alu(4'd9, 5'h10, 32'h1); ld(4'd4, 5'h10, 32'hDEAD); expect_wb(4'd9, 5'h10, 32'h1, cyc + 1);
    tick(); ld_valid = 1'b0;
    check("pending_r4", pending, 16'h0010);
    alu(4'd4, 5'h10, 32'h7); expect_wb(4'd4, 5'h10, 32'h7, cyc + 1);
    tick(); check("pending_killed", pending, 16'h0);
    idle(); tick(); tick();
    // FIFO must be empty again: a fresh load bypasses with latency 1
    ld(4'd6, 5'h10, 32'h6666); expect_wb(4'd6, 5'h10, 32'h6666, cyc + 1);
    tick(); idle(); tick();

    // load and ALU to the same register in the same cycle: load is dead
    alu(4'd7, 5'h10, 32'h77); ld(4'd7, 5'h10, 32'h99); expect_wb(4'd7, 5'h10, 32'h77, cyc + 1);
    tick(); check("pending_same_cycle", pending, 16'h0);
    idle(); tick(); tick();

    // r15 from ALU and from a bypassed load
    alu(4'd15, 5'h10, 32'h0000_1004); expect_wb(4'd15, 5'h10, 32'h0000_1004, cyc + 1);
    tick(); idle();
    check("branch_alu", {branch, wr_enable, branch_target}, {2'b10, 30'h401});
    ld(4'd15, 5'h10, 32'h0000_2008); expect_wb(4'd15, 5'h10, 32'h0000_2008, cyc + 1);
    tick(); idle(); tick();

    // async reset with two queued loads
    alu(4'd1, 5'h10, 32'h10); ld(4'd2, 5'h10, 32'h20); expect_wb(4'd1, 5'h10, 32'h10, cyc + 1);
    tick();
    alu(4'd3, 5'h10, 32'h30); ld(4'd5, 5'h10, 32'h50); expect_wb(4'd3, 5'h10, 32'h30, cyc + 1);
    tick();
    check("pending_pre_reset", pending, 16'h0024);
    @(negedge clk); #1;
    idle();
    rst_n = 1'b0;
    #1;
    check("async_reset",
          {wr_enable, branch, ld_ready, wr_r, wr_mode, wr_value, branch_target, pending},
          {3'b001, 4'h0, 5'h0, 32'h0, 30'h0, 16'h0});
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("post_reset", {ld_ready, pending}, {1'b1, 16'h0});
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
